dff_reg_arbiter: RTL and testbench
==================================

Name: dff_reg_arbiter

Overview:
Round-robin arbiter and write sequencer for a shared WIDTH-bit register built from d_ff storage semantics (reset clears, clock edge captures data). N requesters compete for write access; the block grants one requester at a time, captures its data into the register, acknowledges the write, and supports a bounded locked burst. It sits between multiple producer blocks and a single shared state register.

Parameters:
N, 4, number of requesters (2..8)
WIDTH, 8, data width of shared register
MAX_LOCK, 4, max consecutive granted cycles for one owner (GRANT cycle + LOCKED cycles), >=1

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  N  per-requester write request, level
lock  input  N  per-requester burst hold request, sampled only for current owner
wdata  input  N*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
grant  output  N  one-hot registered grant, 0 when idle
ack  output  N  one-hot one-cycle pulse, write committed on previous edge
q  output  WIDTH  shared register contents
owner  output  clog2(N)  index of last requester that committed a write
valid  output  1  high once any write has committed since reset

Behaviour:
- Reset (reset=0, async, immediate): q=0, grant=0, ack=0, owner=0, valid=0, state=IDLE, rr pointer ptr=0, lock counter=0. Reset mid-burst aborts with no write.
- States: IDLE, GRANT, LOCKED.
- IDLE: if req!=0 at edge, choose first i with req[i]=1 scanning ptr, ptr+1, ... mod N; grant<=onehot(i); state<=GRANT; cnt<=1. If req=0, stay; grant=0.
- GRANT (grant[i]=1): at edge, if req[i]=1: q<=wdata slice i, ack[i]<=1, owner<=i, valid<=1. If req[i]=0: abort, no write, no ack.
- GRANT exit: if req[i]=1 and lock[i]=1 and cnt<MAX_LOCK -> LOCKED, grant held, cnt<=cnt+1; else -> IDLE, grant<=0, ptr<=(i+1) mod N (also on abort).
- LOCKED: each edge with req[i]=1 writes and acks as in GRANT. Exit to IDLE (grant<=0, ptr<=(i+1) mod N) when req[i]=0 (no write that cycle), lock[i]=0 (final write still done if req[i]=1), or cnt==MAX_LOCK (final write done, forced release). Otherwise cnt<=cnt+1.
- MAX_LOCK=1: LOCKED never entered.
- Latency: req sampled at edge k -> grant high cycle k..k+1 -> q updated and ack high after edge k+1. Minimum 2 cycles req-to-ack, 1 idle cycle between different owners.
- ack is registered, one-hot, high exactly one cycle per committed write; ack never high without q change event (q may equal old value).
- Other requesters' req/lock/wdata ignored while a grant is held; no preemption.
- ptr wrap: index N-1 -> 0.
- Requesters must hold wdata stable while grant[i]=1; q captures the value present at the committing edge.

Test Plan:
- Reset: reset=0 with req=4'b1111, wdata all 8'hFF -> q=0, grant=0, ack=0, valid=0 throughout; release reset -> grant=4'b0001 after first edge.
- Single write: req=4'b0100, wdata[2]=8'hA5 -> grant=4'b0100 one cycle, then q=8'hA5, ack=4'b0100 one cycle, owner=2, valid=1, grant=0.
- Round robin: req=4'b1111 held, distinct data 8'h10..8'h13 -> grant order 0,1,2,3,0, q sequence 10,11,12,13,10, one idle cycle between grants.
- Locked burst cap: MAX_LOCK=4, requester 1 holds req=1, lock=1, data increments 1..6 -> exactly 4 acks, q=8'h04, then grant released and next requester (if any) served.
- Abort: requester 3 drops req during GRANT cycle -> no ack, q unchanged, next grant scan starts at 0.
- Reset mid-burst: reset=0 during LOCKED -> q=0, grant=0 immediately (before next edge), ptr=0 after release.

Source files
------------

// File: rtl/dff_reg_arbiter.sv
// -----------------------------------------------------------------------------
// dff_reg_arbiter
//
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// N producers raise req; one is granted at a time, its data slice is captured
// into q on the committing edge, and a one-cycle ack pulse reports the write.
// An owner holding lock keeps the grant for a burst of at most MAX_LOCK
// consecutive granted cycles.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   req    : [N]        per-requester write request (level)
//   lock   : [N]        per-requester burst hold, looked at for the owner only
//   wdata  : [N*WIDTH]  requester i data at [i*WIDTH +: WIDTH]
//   grant  : [N]        registered one-hot grant, 0 when idle
//   ack    : [N]        one-hot pulse, write committed on the previous edge
//   q      : [WIDTH]    shared register contents
//   owner  : [clog2(N)] index of the last requester that committed a write
//   valid  : 1          set once any write has committed since reset
// -----------------------------------------------------------------------------
module dff_reg_arbiter #(
  parameter int N        = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           req,
  input  logic [N-1:0]           lock,
  input  logic [N*WIDTH-1:0]     wdata,
  output logic [N-1:0]           grant,
  output logic [N-1:0]           ack,
  output logic [WIDTH-1:0]       q,
  output logic [$clog2(N)-1:0]   owner,
  output logic                   valid
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LOCK);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    LOCKED
  } state_t;

  state_t          state, state_n;
  logic [N-1:0]    grant_n, ack_n;
  logic [WIDTH-1:0] q_n;
  logic [IW-1:0]   owner_n;
  logic            valid_n;
  logic [IW-1:0]   ptr, ptr_n;     // round-robin scan start
  logic [IW-1:0]   cur, cur_n;     // index of the requester currently granted
  logic [CW-1:0]   cnt, cnt_n;     // granted cycles used by the current owner
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cur_inc;

  // First requester at or after ptr, wrapping N-1 -> 0. Only consumed in IDLE
  // when req is non-zero, so the fallback value is irrelevant.
  always_comb begin : pick_blk
    logic found;
    int   j;
    found    = 1'b0;
    j        = 0;
    pick_idx = ptr;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found    = 1'b1;
        pick_idx = IW'(j);
      end
    end
  end

  assign cur_inc = (cur == IW'(N - 1)) ? '0 : cur + IW'(1);

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    grant_n = grant;
    ack_n   = '0;
    q_n     = q;
    owner_n = owner;
    valid_n = valid;
    ptr_n   = ptr;
    cur_n   = cur;
    cnt_n   = cnt;

    unique case (state)
      IDLE: begin
        if (req != '0) begin
          cur_n          = pick_idx;
          grant_n        = '0;
          grant_n[pick_idx] = 1'b1;
          cnt_n          = CW'(1);
          state_n        = GRANT;
        end
      end

      // GRANT and LOCKED commit and leave under identical rules; the two
      // states only differ in how far into the burst cnt has advanced.
      GRANT, LOCKED: begin
        if (req[cur]) begin
          q_n     = wdata[int'(cur)*WIDTH +: WIDTH];
          ack_n   = grant;
          owner_n = cur;
          valid_n = 1'b1;
        end
        if (req[cur] && lock[cur] && (cnt < MAX_CNT)) begin
          cnt_n   = cnt + CW'(1);
          state_n = LOCKED;
        end else begin
          // Release, including the abort case where req dropped.
          grant_n = '0;
          ptr_n   = cur_inc;
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      ack   <= '0;
      q     <= '0;
      owner <= '0;
      valid <= 1'b0;
      ptr   <= '0;
      cur   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      ack   <= ack_n;
      q     <= q_n;
      owner <= owner_n;
      valid <= valid_n;
      ptr   <= ptr_n;
      cur   <= cur_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dff_reg_arbiter
//
// Self-checking bench for dff_reg_arbiter (N=4, WIDTH=8, MAX_LOCK=4): reset
// behaviour, a table of single-write and round-robin vectors, hand-written
// burst / abort / mid-burst-reset sequences, and a random phase compared
// against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_dff_reg_arbiter;

  localparam int N        = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_LOCK = 4;

  logic                 clk;
  logic                 reset;
  logic [N-1:0]         req;
  logic [N-1:0]         lock;
  logic [N*WIDTH-1:0]   wdata;
  logic [N-1:0]         grant;
  logic [N-1:0]         ack;
  logic [WIDTH-1:0]     q;
  logic [1:0]           owner;
  logic                 valid;

  int n_cmp  = 0;
  int n_fail = 0;

  dff_reg_arbiter #(.N(N), .WIDTH(WIDTH), .MAX_LOCK(MAX_LOCK)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .lock  (lock),
    .wdata (wdata),
    .grant (grant),
    .ack   (ack),
    .q     (q),
    .owner (owner),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] wdata;
    logic [N-1:0]       eg;
    logic [N-1:0]       ea;
    logic [WIDTH-1:0]   eq;
    logic [1:0]         eo;
    logic               ev;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic [N-1:0] r, logic [N*WIDTH-1:0] d,
                              logic [N-1:0] g, logic [N-1:0] a,
                              logic [WIDTH-1:0] qq, logic [1:0] o, logic v);
    vec_t t;
    t.req = r; t.wdata = d; t.eg = g; t.ea = a; t.eq = qq; t.eo = o; t.ev = v;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [N-1:0] eg, input logic [N-1:0] ea,
                           input logic [WIDTH-1:0] eq, input logic [1:0] eo, input logic ev);
    check({tag, ".grant"}, 32'(grant), 32'(eg));
    check({tag, ".ack"},   32'(ack),   32'(ea));
    check({tag, ".q"},     32'(q),     32'(eq));
    check({tag, ".owner"}, 32'(owner), 32'(eo));
    check({tag, ".valid"}, 32'(valid), 32'(ev));
  endtask

  // One clock edge; outputs are then sampled at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: tracks who holds the grant and how many granted cycles
  // they have used, advancing once per edge from the inputs at that edge.
  // ---------------------------------------------------------------------------
  int               m_gi;      // granted requester, -1 when idle
  int               m_ptr;
  int               m_used;
  int               m_owner;
  logic             m_valid;
  logic [WIDTH-1:0] m_q;
  logic [N-1:0]     m_ack;

  task automatic model_reset();
    m_gi = -1; m_ptr = 0; m_used = 0; m_owner = 0; m_valid = 1'b0; m_q = '0; m_ack = '0;
  endtask

  task automatic model_step();
    m_ack = '0;
    if (m_gi < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_gi < 0 && req[(m_ptr + k) % N]) m_gi = (m_ptr + k) % N;
      end
      m_used = 1;
    end else begin
      if (req[m_gi]) begin
        m_q     = wdata[m_gi*WIDTH +: WIDTH];
        m_ack   = N'(1) << m_gi;
        m_owner = m_gi;
        m_valid = 1'b1;
      end
      if (req[m_gi] && lock[m_gi] && m_used < MAX_LOCK) begin
        m_used++;
      end else begin
        m_ptr = (m_gi + 1) % N;
        m_gi  = -1;
      end
    end
  endtask

  function automatic logic [N-1:0] model_grant();
    return (m_gi < 0) ? '0 : (N'(1) << m_gi);
  endfunction

  localparam logic [N*WIDTH-1:0] D_A5 = {8'h00, 8'hA5, 8'h00, 8'h00};
  localparam logic [N*WIDTH-1:0] D_RR = {8'h13, 8'h12, 8'h11, 8'h10};

  initial begin
    int acks;

    // -------------------------------------------------------------------------
    // Single write (ptr starts at 0) followed by round robin with all
    // requesters held. Wrap 3 -> 0 is exercised as the scan starts at 3.
    // -------------------------------------------------------------------------
    tbl[0]  = mk(4'b0100, D_A5, 4'b0100, 4'b0000, 8'h00, 2'd0, 1'b0);
    tbl[1]  = mk(4'b0100, D_A5, 4'b0000, 4'b0100, 8'hA5, 2'd2, 1'b1);
    tbl[2]  = mk(4'b0000, D_A5, 4'b0000, 4'b0000, 8'hA5, 2'd2, 1'b1);
    tbl[3]  = mk(4'b1111, D_RR, 4'b1000, 4'b0000, 8'hA5, 2'd2, 1'b1);
    tbl[4]  = mk(4'b1111, D_RR, 4'b0000, 4'b1000, 8'h13, 2'd3, 1'b1);
    tbl[5]  = mk(4'b1111, D_RR, 4'b0001, 4'b0000, 8'h13, 2'd3, 1'b1);
    tbl[6]  = mk(4'b1111, D_RR, 4'b0000, 4'b0001, 8'h10, 2'd0, 1'b1);
    tbl[7]  = mk(4'b1111, D_RR, 4'b0010, 4'b0000, 8'h10, 2'd0, 1'b1);
    tbl[8]  = mk(4'b1111, D_RR, 4'b0000, 4'b0010, 8'h11, 2'd1, 1'b1);
    tbl[9]  = mk(4'b1111, D_RR, 4'b0100, 4'b0000, 8'h11, 2'd1, 1'b1);
    tbl[10] = mk(4'b1111, D_RR, 4'b0000, 4'b0100, 8'h12, 2'd2, 1'b1);
    tbl[11] = mk(4'b1111, D_RR, 4'b1000, 4'b0000, 8'h12, 2'd2, 1'b1);
    tbl[12] = mk(4'b1111, D_RR, 4'b0000, 4'b1000, 8'h13, 2'd3, 1'b1);
    tbl[13] = mk(4'b0000, D_RR, 4'b0000, 4'b0000, 8'h13, 2'd3, 1'b1);

    // -------------------------------------------------------------------------
    // Reset held with everyone requesting: nothing may move across edges.
    // -------------------------------------------------------------------------
    reset = 1'b0;
    req   = 4'b1111;
    lock  = 4'b0000;
    wdata = {4{8'hFF}};
    @(negedge clk);
    check_all("rst_hold0", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("rst_hold", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
    end
    reset = 1'b1;
    tick();
    check_all("rst_rel_grant", 4'b0001, 4'b0000, 8'h00, 2'd0, 1'b0);
    tick();
    check_all("rst_rel_ack", 4'b0000, 4'b0001, 8'hFF, 2'd0, 1'b1);
    req = 4'b0000;
    tick();
    check_all("rst_rel_idle", 4'b0000, 4'b0000, 8'hFF, 2'd0, 1'b1);

    // -------------------------------------------------------------------------
    // Table vectors from a fresh reset.
    // -------------------------------------------------------------------------
    pulse_reset();
    for (int i = 0; i < 14; i++) begin
      req   = tbl[i].req;
      wdata = tbl[i].wdata;
      lock  = '0;
      tick();
      check_all($sformatf("vec%0d", i), tbl[i].eg, tbl[i].ea, tbl[i].eq, tbl[i].eo, tbl[i].ev);
    end

    // -------------------------------------------------------------------------
    // Locked burst cap: requester 1 holds req+lock with data 1,2,3,...;
    // requester 2 waits. Exactly MAX_LOCK acks, then requester 2 is served.
    // -------------------------------------------------------------------------
    req  = 4'b0110;
    lock = 4'b0010;
    acks = 0;
    for (int e = 1; e <= 6; e++) begin
      wdata = {8'h00, 8'h22, 8'(e - 1), 8'h00};
      tick();
      if (ack == 4'b0010) acks++;
      if (e == 1)
        check_all("burst_e1", 4'b0010, 4'b0000, 8'h13, 2'd3, 1'b1);
      else if (e <= 5)
        check_all($sformatf("burst_e%0d", e), (e < 5) ? 4'b0010 : 4'b0000,
                  4'b0010, 8'(e - 1), 2'd1, 1'b1);
      else
        check_all("burst_next", 4'b0100, 4'b0000, 8'h04, 2'd1, 1'b1);
    end
    check("burst_ack_count", 32'(acks), 32'(MAX_LOCK));
    tick();
    check_all("burst_next_ack", 4'b0000, 4'b0100, 8'h22, 2'd2, 1'b1);

    // -------------------------------------------------------------------------
    // Abort: requester 3 is granted then drops req; no write, and the next
    // scan starts at 0 (requester 0 wins over a re-raised requester 3).
    // -------------------------------------------------------------------------
    lock  = 4'b0000;
    req   = 4'b1000;
    wdata = {8'hEE, 8'h00, 8'h00, 8'h00};
    tick();
    check_all("abort_grant", 4'b1000, 4'b0000, 8'h22, 2'd2, 1'b1);
    req = 4'b0001;
    tick();
    check_all("abort_drop", 4'b0000, 4'b0000, 8'h22, 2'd2, 1'b1);
    req = 4'b1001;
    tick();
    check_all("abort_rescan", 4'b0001, 4'b0000, 8'h22, 2'd2, 1'b1);

    // -------------------------------------------------------------------------
    // Reset in the middle of a locked burst clears everything at once.
    // -------------------------------------------------------------------------
    req = 4'b0000;
    tick();
    check_all("mid_abort0", 4'b0000, 4'b0000, 8'h22, 2'd2, 1'b1);
    req   = 4'b0010;
    lock  = 4'b0010;
    wdata = {8'h00, 8'h00, 8'h77, 8'h00};
    tick();
    check_all("mid_grant", 4'b0010, 4'b0000, 8'h22, 2'd2, 1'b1);
    tick();
    check_all("mid_w1", 4'b0010, 4'b0010, 8'h77, 2'd1, 1'b1);
    tick();
    check_all("mid_w2", 4'b0010, 4'b0010, 8'h77, 2'd1, 1'b1);
    reset = 1'b0;
    #1;
    check_all("mid_rst_async", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
    #1;
    reset = 1'b1;
    req   = 4'b0011;
    lock  = 4'b0000;
    tick();
    check_all("mid_rst_ptr0", 4'b0001, 4'b0000, 8'h00, 2'd0, 1'b0);

    // -------------------------------------------------------------------------
    // Random traffic against the reference model.
    // -------------------------------------------------------------------------
    req  = '0;
    lock = '0;
    pulse_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      req   = ($urandom_range(0, 3) == 0) ? 4'b0000 : N'($urandom_range(0, 15));
      lock  = ($urandom_range(0, 1) == 0) ? 4'b1111 : N'($urandom_range(0, 15));
      wdata = {$urandom};
      model_step();
      tick();
      check_all($sformatf("rnd%0d", c), model_grant(), m_ack, m_q, 2'(m_owner), m_valid);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
